// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and defaults.
//   uart_tx_state_t : transmitter FSM states
//   UART_IDLE_LVL   : line level while idle / during stop bits
//   UART_DATA_W/DIV_W : default frame width and divider width
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
    localparam logic UART_IDLE_LVL = 1'b1;
    localparam int UART_DATA_W = 8;
    localparam int UART_DIV_W = 16;
endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: byte handshake between driver and transmitter.
//   tx_data  : byte to send
//   tx_valid : tx_data is valid
//   tx_ready : transmitter accepts tx_data this cycle
interface uart_tx_core_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic tx_valid;
    logic tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period down-counter.
//   clk, rst : clock, async active-high reset
//   load     : restart the period with load_val (frame accept)
//   run      : frame in progress, count down and reload on wrap
//   load_val : period minus one
//   bit_end  : high on the last cycle of each bit period
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             run,
    input  logic [DIV_W-1:0] load_val,
    output logic             bit_end
);
    logic [DIV_W-1:0] cnt;

    assign bit_end = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (run)
            cnt <= (cnt == '0) ? load_val : cnt - DIV_W'(1);
    end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter, start + DATA_W bits LSB first + 1/2 stop bits.
//   clk, rst : clock, async active-high reset
//   comp     : bit period in cycles (0 and 1 both mean 1)
//   stop2    : 0 = one stop bit, 1 = two stop bits
//   tr_en    : enables new accepts; a running frame always completes
//   bus      : tx_data/tx_valid/tx_ready handshake (slave side)
//   busy     : frame in progress
//   uart_tx  : registered serial line, idle high
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DIV_W  = UART_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] comp,
    input  logic             stop2,
    input  logic             tr_en,
    uart_tx_core_if.slave    bus,
    output logic             busy,
    output logic             uart_tx
);
    localparam int BCW = $clog2(DATA_W + 1);

    uart_tx_state_t    state;
    logic [DATA_W-1:0] shift;
    logic [DIV_W-1:0]  comp_q;
    logic              stop2_q;
    logic [BCW-1:0]    bit_cnt;
    logic              bit_end;
    logic              last_stop;
    logic              accept;
    logic [DIV_W-1:0]  per_sel;
    logic [DIV_W-1:0]  load_val;

    // stop bits run 0..stop_n-1, and stop_n-1 equals stop2
    assign last_stop    = (state == STOP) && bit_end && (bit_cnt == BCW'(stop2_q));
    assign bus.tx_ready = tr_en && ((state == IDLE) || last_stop);
    assign accept       = bus.tx_valid && bus.tx_ready;

    // a new frame starts from the live comp; a running frame uses its latched copy
    assign per_sel  = accept ? comp : comp_q;
    assign load_val = (per_sel == '0) ? '0 : per_sel - DIV_W'(1);

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .run      (state != IDLE),
        .load_val (load_val),
        .bit_end  (bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            uart_tx <= UART_IDLE_LVL;
            busy    <= 1'b0;
            shift   <= '0;
            comp_q  <= '0;
            stop2_q <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            state   <= START;
            uart_tx <= 1'b0;
            busy    <= 1'b1;
            shift   <= bus.tx_data;
            comp_q  <= comp;
            stop2_q <= stop2;
            bit_cnt <= '0;
        end else if (bit_end) begin
            case (state)
                START: begin
                    state   <= DATA;
                    uart_tx <= shift[0];
                    shift   <= shift >> 1;
                end
                DATA: begin
                    if (bit_cnt == BCW'(DATA_W - 1)) begin
                        state   <= STOP;
                        uart_tx <= UART_IDLE_LVL;
                        bit_cnt <= '0;
                    end else begin
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
